// File: rtl/wb_best_match_reporter.sv
// wb_best_match_reporter
// Tracks the best-match index and improvement count over one search frame,
// converts the final linear index to (row, col) by repeated subtraction and
// presents the result over a valid/ready handshake.
module wb_best_match_reporter #(
  parameter int unsigned FRAME_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        frame_done,
  input  logic        WB_NewLowestMin,
  input  logic [15:0] WB_FinalBossIndex,
  input  logic        res_ready,
  output logic        res_valid,
  output logic [15:0] res_index,
  output logic [15:0] res_row,
  output logic [15:0] res_col,
  output logic [15:0] res_update_count,
  output logic        res_found,
  output logic        busy
);

  localparam logic [15:0] FW = 16'(FRAME_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DIVIDE = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] best_index_q, best_index_d;
  logic [15:0] count_q, count_d;
  logic        found_q, found_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quot_q, quot_d;
  logic        res_valid_q, res_valid_d;
  logic [15:0] res_index_q, res_index_d;
  logic [15:0] res_row_q, res_row_d;
  logic [15:0] res_col_q, res_col_d;
  logic [15:0] res_count_q, res_count_d;
  logic        res_found_q, res_found_d;

  // Next-state and datapath: frame tracking, iterative divide, result hold
  always_comb begin
    state_d      = state_q;
    best_index_d = best_index_q;
    count_d      = count_q;
    found_d      = found_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    res_valid_d  = res_valid_q;
    res_index_d  = res_index_q;
    res_row_d    = res_row_q;
    res_col_d    = res_col_q;
    res_count_d  = res_count_q;
    res_found_d  = res_found_q;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d      = SEARCH;
          best_index_d = '0;
          count_d      = '0;
          found_d      = 1'b0;
        end
      end
      SEARCH: begin
        if (frame_start) begin
          // restart wins over any update or frame_done in the same cycle
          best_index_d = '0;
          count_d      = '0;
          found_d      = 1'b0;
        end else begin
          if (WB_NewLowestMin) begin
            best_index_d = WB_FinalBossIndex;
            found_d      = 1'b1;
            if (count_q != '1) count_d = count_q + 16'd1;
          end
          if (frame_done) begin
            state_d = DIVIDE;
            rem_d   = WB_NewLowestMin ? WB_FinalBossIndex : best_index_q;
            quot_d  = '0;
          end
        end
      end
      DIVIDE: begin
        if (rem_q >= FW) begin
          rem_d  = rem_q - FW;
          quot_d = quot_q + 16'd1;
        end else begin
          res_row_d   = quot_q;
          res_col_d   = rem_q;
          res_index_d = best_index_q;
          res_count_d = count_q;
          res_found_d = found_q;
          res_valid_d = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      best_index_q <= '0;
      count_q      <= '0;
      found_q      <= 1'b0;
      rem_q        <= '0;
      quot_q       <= '0;
      res_valid_q  <= 1'b0;
      res_index_q  <= '0;
      res_row_q    <= '0;
      res_col_q    <= '0;
      res_count_q  <= '0;
      res_found_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      best_index_q <= best_index_d;
      count_q      <= count_d;
      found_q      <= found_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      res_valid_q  <= res_valid_d;
      res_index_q  <= res_index_d;
      res_row_q    <= res_row_d;
      res_col_q    <= res_col_d;
      res_count_q  <= res_count_d;
      res_found_q  <= res_found_d;
    end
  end

  assign res_valid        = res_valid_q;
  assign res_index        = res_index_q;
  assign res_row          = res_row_q;
  assign res_col          = res_col_q;
  assign res_update_count = res_count_q;
  assign res_found        = res_found_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_wb_best_match_reporter.sv
// Scoreboard bench for wb_best_match_reporter (FRAME_WIDTH=64).
module tb_wb_best_match_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_done = 1'b0;
  logic        WB_NewLowestMin = 1'b0;
  logic [15:0] WB_FinalBossIndex = '0;
  logic        res_ready = 1'b0;
  logic        res_valid;
  logic [15:0] res_index, res_row, res_col, res_update_count;
  logic        res_found, busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] idx;
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] cnt;
    logic        found;
  } exp_t;

  exp_t sb[$];

  wb_best_match_reporter #(.FRAME_WIDTH(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_start       (frame_start),
    .frame_done        (frame_done),
    .WB_NewLowestMin   (WB_NewLowestMin),
    .WB_FinalBossIndex (WB_FinalBossIndex),
    .res_ready         (res_ready),
    .res_valid         (res_valid),
    .res_index         (res_index),
    .res_row           (res_row),
    .res_col           (res_col),
    .res_update_count  (res_update_count),
    .res_found         (res_found),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: a handshake will occur at the next rising edge; compare it
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_index", 32'(res_index), 32'(e.idx));
        chk("sb_row",   32'(res_row),   32'(e.row));
        chk("sb_col",   32'(res_col),   32'(e.col));
        chk("sb_count", 32'(res_update_count), 32'(e.cnt));
        chk("sb_found", 32'(res_found), 32'(e.found));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic update(input logic [15:0] idx);
    WB_NewLowestMin = 1'b1;
    WB_FinalBossIndex = idx;
    tick();
    WB_NewLowestMin = 1'b0;
  endtask

  // Issue frame_done (optionally with a coincident update) and record the expected result
  task automatic finish_frame(input logic upd, input logic [15:0] idx, input exp_t e);
    sb.push_back(e);
    frame_done = 1'b1;
    if (upd) begin
      WB_NewLowestMin = 1'b1;
      WB_FinalBossIndex = idx;
    end
    tick();
    frame_done = 1'b0;
    WB_NewLowestMin = 1'b0;
  endtask

  // Count edges after E0 until res_valid, bounded
  task automatic wait_valid(input string name, input int exp_lat);
    int k = 0;
    while (!res_valid && k < 70000) begin
      tick();
      k++;
    end
    chk(name, 32'(k), 32'(exp_lat));
  endtask

  task automatic handshake(input string name);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({name, "_valid_low"}, 32'(res_valid), 32'd0);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    #2;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_index", 32'(res_index), 32'd0);
    chk("rst_row", 32'(res_row), 32'd0);
    chk("rst_col", 32'(res_col), 32'd0);
    chk("rst_count", 32'(res_update_count), 32'd0);
    chk("rst_found", 32'(res_found), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Two updates, 200/64 -> row 3 col 8; hold ready low for 5 cycles
    start_frame();
    chk("t1_busy_high", 32'(busy), 32'd1);
    update(16'd10);
    update(16'd200);
    e = '{idx: 16'd200, row: 16'd3, col: 16'd8, cnt: 16'd2, found: 1'b1};
    finish_frame(1'b0, 16'd0, e);
    wait_valid("t1_latency", 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold_valid", 32'(res_valid), 32'd1);
      chk("t1_hold_row", 32'(res_row), 32'd3);
      chk("t1_hold_col", 32'(res_col), 32'd8);
      chk("t1_hold_index", 32'(res_index), 32'd200);
    end
    handshake("t1");
    chk("t1_idle_row", 32'(res_row), 32'd3);
    chk("t1_idle_col", 32'(res_col), 32'd8);
    chk("t1_idle_index", 32'(res_index), 32'd200);

    // Empty frame, ready high before valid
    start_frame();
    res_ready = 1'b1;
    e = '{idx: 16'd0, row: 16'd0, col: 16'd0, cnt: 16'd0, found: 1'b0};
    finish_frame(1'b0, 16'd0, e);
    wait_valid("t2_latency", 1);
    tick();
    res_ready = 1'b0;
    chk("t2_valid_low", 32'(res_valid), 32'd0);
    chk("t2_busy_low", 32'(busy), 32'd0);

    // Update coincident with frame_done: 130 -> row 2 col 2
    start_frame();
    update(16'd5);
    e = '{idx: 16'd130, row: 16'd2, col: 16'd2, cnt: 16'd2, found: 1'b1};
    finish_frame(1'b1, 16'd130, e);
    wait_valid("t3_latency", 3);
    handshake("t3");

    // Reset during DIVIDE with index 1000: no result, outputs cleared at once
    start_frame();
    update(16'd1000);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(res_valid), 32'd0);
    chk("t4_rst_index", 32'(res_index), 32'd0);
    chk("t4_rst_row", 32'(res_row), 32'd0);
    chk("t4_rst_col", 32'(res_col), 32'd0);
    chk("t4_rst_count", 32'(res_update_count), 32'd0);
    chk("t4_rst_found", 32'(res_found), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Following frame: 65 -> row 1 col 1
    start_frame();
    update(16'd65);
    e = '{idx: 16'd65, row: 16'd1, col: 16'd1, cnt: 16'd1, found: 1'b1};
    finish_frame(1'b0, 16'd0, e);
    wait_valid("t5_latency", 2);
    handshake("t5");

    // 70000 updates saturate the count; frame_start in REPORT ignored
    start_frame();
    WB_NewLowestMin = 1'b1;
    WB_FinalBossIndex = 16'd300;
    for (int i = 0; i < 70000; i++) tick();
    WB_NewLowestMin = 1'b0;
    e = '{idx: 16'd300, row: 16'd4, col: 16'd44, cnt: 16'hFFFF, found: 1'b1};
    finish_frame(1'b0, 16'd0, e);
    wait_valid("t6_latency", 5);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t6_still_valid", 32'(res_valid), 32'd1);
    chk("t6_still_busy", 32'(busy), 32'd1);
    chk("t6_index", 32'(res_index), 32'd300);
    chk("t6_count_sat", 32'(res_update_count), 32'hFFFF);
    handshake("t6");

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_best_match_reporter.md
# wb_best_match_reporter

Consumes the writeback-stage best-match stream (a one-cycle "new lowest minimum" pulse plus the 16-bit index of the current best search position). Over one search frame it tracks the final best index and the number of improvements. At end of frame it converts the linear index to (row, col) by iterative subtraction, with no divider. The result is presented to the downstream result sink over a valid/ready handshake.

## Interface
Parameters:
- FRAME_WIDTH, 64, search positions per row; legal range 1..65535.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse that begins a new search frame.
- frame_done  in  1  one-cycle pulse marking the last writeback cycle of the frame.
- WB_NewLowestMin  in  1  one-cycle pulse; WB_FinalBossIndex holds a new best index.
- WB_FinalBossIndex  in  16  best-match linear index; sampled only when WB_NewLowestMin=1.
- res_ready  in  1  downstream accepts the result.
- res_valid  out  1  result available.
- res_index  out  16  final best linear index.
- res_row  out  16  res_index / FRAME_WIDTH.
- res_col  out  16  res_index % FRAME_WIDTH.
- res_update_count  out  16  number of WB_NewLowestMin pulses in the frame; saturates at 16'hFFFF.
- res_found  out  1  at least one update occurred in the frame.
- busy  out  1  high in SEARCH, DIVIDE and REPORT.

## Operation
- Reset, asynchronous on rst_n=0:
  - state=IDLE.
  - All outputs 0: res_valid, res_index, res_row, res_col, res_update_count, res_found, busy.
  - Internal best_index, count, found, rem and quot all 0.
- States: IDLE, SEARCH, DIVIDE, REPORT.
- IDLE:
  - Result outputs hold their last values.
  - frame_start -> SEARCH; clears best_index, count and found.
  - frame_done and WB_NewLowestMin are ignored.
- SEARCH:
  - On WB_NewLowestMin: best_index<=WB_FinalBossIndex, found<=1, count<=count+1 (holds at 16'hFFFF).
  - On frame_done -> DIVIDE; loads rem<=best_index (or the incoming index if WB_NewLowestMin is high in the same cycle) and quot<=0.
  - An update coinciding with frame_done is included in index, count and found.
  - frame_start in SEARCH restarts the frame (clears best_index, count and found, stays in SEARCH). frame_start has priority over frame_done in the same cycle.
- DIVIDE:
  - Each cycle with rem>=FRAME_WIDTH: rem<=rem-FRAME_WIDTH, quot<=quot+1.
  - When rem<FRAME_WIDTH:
    - Load res_row<=quot, res_col<=rem, res_index<=best_index, res_update_count<=count, res_found<=found.
    - Set res_valid<=1 and go to REPORT.
  - found=0 gives index 0, row 0, col 0.
  - All subtraction is unsigned 16-bit; rem never underflows.
- REPORT:
  - res_valid=1; all res_* outputs stable until the handshake.
  - res_valid&&res_ready at a rising edge -> IDLE, res_valid=0 from the next cycle.
- frame_start, frame_done and WB_NewLowestMin are ignored in DIVIDE and REPORT; the upstream source must not start a frame while busy=1.

## Timing
- frame_done sampled at edge E0 -> DIVIDE from E0.
- With q = index/FRAME_WIDTH, res_valid rises after edge E0+q+1, which gives a latency of q+1 cycles. Worst case, FRAME_WIDTH=1 and index 65535, is 65536 cycles.
- Result outputs update only on the DIVIDE->REPORT edge; they never glitch during REPORT.
- res_ready may be high before res_valid. The handshake completes at the first edge where both are high; the minimum REPORT duration is 1 cycle.
- busy rises the cycle after frame_start and falls the cycle after the handshake.
- Reset asserted mid-DIVIDE or mid-REPORT clears everything immediately; no result is emitted.

## Test plan
- FRAME_WIDTH=64. frame_start, then updates with index 10 and index 200, then frame_done at E0 -> res_valid after E0+4; row=3, col=8, index=200, count=2, found=1.
- frame_start then frame_done with no updates -> res_valid after E0+1; row=0, col=0, index=0, count=0, found=0.
- WB_NewLowestMin (index 130) in the same cycle as frame_done -> row=2, col=2, index=130, count includes the pulse.
- res_ready held low for 5 cycles in REPORT -> res_valid and all res_* are constant. Raise res_ready -> res_valid=0 the next cycle, busy=0, and outputs retain their values in IDLE.
- rst_n pulsed low during DIVIDE with index 1000 -> all outputs 0 immediately. A following frame with index 65 -> row=1, col=1.
- frame_start during REPORT, and 70000 updates in one frame -> frame_start is ignored (still REPORT with the same result), and res_update_count saturates at 16'hFFFF.
